mux_scan_ctrl: RTL and testbench

- Sequential front-end that feeds the NAND-based 4:1 multiplexer stage.
- Steps through the enabled channels in a round-robin scan.
- Drives the mux's active-low one-hot select lines, waits a settle interval, then captures the selected channel's data.
- Presents each capture to the consumer over a valid/ready handshake.

---
 rtl/mux_scan_pkg.sv | 20 ++
 rtl/mux_scan_next.sv | 26 ++
 rtl/mux_scan_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux_scan_ctrl scan front-end.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int N_CH_DEF       = 4;
    localparam int DWIDTH_DEF     = 8;
    localparam int SETTLE_CYC_DEF = 2;

    localparam logic [N_CH_DEF-1:0] SEL_NONE = '1;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_scan_next.sv
// Finds the lowest set bit of mask strictly above idx; idx = -1 searches from bit 0.
module mux_scan_next
    import mux_scan_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int IDX_W = ch_idx_w(N_CH)
) (
    input  logic [N_CH-1:0]    mask,
    input  logic signed [IDX_W:0] idx,
    output logic               found,
    output logic [IDX_W-1:0]   nxt
);

    // NOTE: found/nxt get defaults before the loop so no path leaves them unassigned (no latch).
    always_comb begin
        found = 1'b0;
        nxt   = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (mask[k] && (k > int'(idx))) begin
                found = 1'b1;
                nxt   = k[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Round-robin scan controller driving the active-low select of a NAND 4:1 mux.
// Optional continuous scan with stop input: define MUX_SCAN_CONT_EN.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int N_CH       = N_CH_DEF,
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N_CH-1:0]            ch_en,
    input  logic [N_CH*DWIDTH-1:0]     data_in,
    output logic [N_CH-1:0]            sel_n,
    output logic                       out_valid,
    input  logic                       out_ready,
`ifdef MUX_SCAN_CONT_EN
    input  logic                       stop,
`endif
    output logic [DWIDTH-1:0]          out_data,
    output logic [ch_idx_w(N_CH)-1:0]  out_ch,
    output logic                       busy,
    output logic                       done
);

    localparam int IDX_W = ch_idx_w(N_CH);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

    state_t              state, state_d;
    logic [N_CH-1:0]     en_q, en_q_d;
    logic [IDX_W-1:0]    cur, cur_d;
    logic [3:0]          cnt, cnt_d;
    logic [N_CH-1:0]     sel_n_d;
    logic                out_valid_d, busy_d, done_d;
    logic [DWIDTH-1:0]   out_data_d;
    logic [IDX_W-1:0]    out_ch_d;

    logic [N_CH-1:0]     srch_mask;
    logic signed [IDX_W:0] srch_from;
    logic                nxt_found;
    logic [IDX_W-1:0]    nxt_ch;
    logic                accept, end_scan;
    logic [IDX_W-1:0]    next_ch;

    // In IDLE the search runs over the live mask from -1; otherwise over en_q above cur.
    assign srch_mask = (state == IDLE) ? ch_en : en_q;
    assign srch_from = (state == IDLE) ? '1 : $signed({1'b0, cur});

    mux_scan_next #(.N_CH(N_CH), .IDX_W(IDX_W)) u_next (
        .mask  (srch_mask),
        .idx   (srch_from),
        .found (nxt_found),
        .nxt   (nxt_ch)
    );

    assign accept = (state == HOLD) && out_valid && out_ready;

`ifdef MUX_SCAN_CONT_EN
    logic             stop_q, stop_q_d;
    logic             first_found;
    logic [IDX_W-1:0] first_ch;

    mux_scan_next #(.N_CH(N_CH), .IDX_W(IDX_W)) u_wrap (
        .mask  (en_q),
        .idx   ('1),
        .found (first_found),
        .nxt   (first_ch)
    );

    assign next_ch  = nxt_found ? nxt_ch : first_ch;
    assign end_scan = stop_q || stop || !(nxt_found || first_found);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stop_q <= 1'b0;
        else     stop_q <= stop_q_d;
    end

    always_comb begin
        stop_q_d = stop_q || (stop && busy);
        if (state == IDLE && start) stop_q_d = 1'b0;
    end
`else
    assign next_ch  = nxt_ch;
    assign end_scan = !nxt_found;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start && ch_en != '0) state_d = SETTLE;
            SETTLE:  if (cnt == 4'd0) state_d = HOLD;
            HOLD:    if (accept) state_d = end_scan ? IDLE : SETTLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        en_q_d      = en_q;
        cur_d       = cur;
        cnt_d       = cnt;
        sel_n_d     = sel_n;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_ch_d    = out_ch;
        busy_d      = busy;
        done_d      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (ch_en != '0) begin
                        en_q_d          = ch_en;
                        cur_d           = nxt_ch;
                        sel_n_d         = '1;
                        sel_n_d[nxt_ch] = 1'b0;
                        cnt_d           = SETTLE_LOAD;
                        busy_d          = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (cnt == 4'd0) begin
                    out_data_d  = data_in[cur*DWIDTH +: DWIDTH];
                    out_ch_d    = cur;
                    out_valid_d = 1'b1;
                    sel_n_d     = '1;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            HOLD: begin
                if (accept) begin
                    out_valid_d = 1'b0;
                    if (end_scan) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        cur_d            = next_ch;
                        sel_n_d          = '1;
                        sel_n_d[next_ch] = 1'b0;
                        cnt_d            = SETTLE_LOAD;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q      <= '0;
            cur       <= '0;
            cnt       <= '0;
            sel_n     <= '1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            en_q      <= en_q_d;
            cur       <= cur_d;
            cnt       <= cnt_d;
            sel_n     <= sel_n_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_ch    <= out_ch_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Self-checking bench for mux_scan_ctrl: table vectors, randomized scans, reset and stall sequences.
module tb_mux_scan_ctrl;
    import mux_scan_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  ch_en = '0;
    logic [31:0] data_in = '0;
    logic [3:0]  sel_n;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        stop = 1'b0;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    mux_scan_ctrl #(.N_CH(4), .DWIDTH(8), .SETTLE_CYC(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ch_en     (ch_en),
        .data_in   (data_in),
        .sel_n     (sel_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef MUX_SCAN_CONT_EN
        .stop      (stop),
`endif
        .out_data  (out_data),
        .out_ch    (out_ch),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] sel_for(input int c);
        logic [3:0] s;
        s = SEL_NONE;
        s[c] = 1'b0;
        return s;
    endfunction

    function automatic int popcount4(input logic [3:0] m);
        int n = 0;
        for (int k = 0; k < 4; k++) if (m[k]) n++;
        return n;
    endfunction

    // One scan: the model is the ordered list of enabled channels, cycled n_caps times.
    task automatic run_scan(input logic [3:0] mask, input logic [31:0] data, input int rdy_pct,
                            input int stall, input bit poke, input int n_caps,
                            output int ncap, output int first_ch);
        int         q_c[$];
        logic [7:0] q_d[$];
        bit         fin, seen_busy, prev_hold, done_next;
        logic [7:0] prev_d;
        logic [1:0] prev_c;
        int         stall_left, k;
        fin = 0; seen_busy = 0; prev_hold = 0; done_next = 0;
        prev_d = '0; prev_c = '0;
        stall_left = stall;
        ncap = 0; first_ch = -1;
        k = 0;
        if (mask != 4'b0) begin
            while (q_c.size() < n_caps) begin
                if (mask[k]) begin
                    q_c.push_back(k);
                    q_d.push_back(data[k*8 +: 8]);
                end
                k = (k + 1) % 4;
            end
        end

        @(negedge clk);
        ch_en = mask; data_in = data; start = 1'b1; stop = 1'b0;
        @(negedge clk);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            start = 1'b0;
            if (busy) seen_busy = 1;
            if (done_next) begin
                check("done_after_last", done, 1);
                done_next = 0;
            end
            if (mask != 4'b0 && cyc < 2) begin
                check("settle_sel", sel_n, sel_for(q_c[0]));
                check("settle_valid", out_valid, 0);
                check("settle_busy", busy, 1);
            end
            if (mask != 4'b0 && cyc == 2) check("first_valid_latency", out_valid, 1);
            if (mask == 4'b0 && cyc == 0) check("empty_done", done, 1);
            if (sel_n != SEL_NONE) begin
                if (q_c.size() == 0) check("sel_extra", sel_n, SEL_NONE);
                else                 check("sel_onehot", sel_n, sel_for(q_c[0]));
            end
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_d);
                check("hold_ch", out_ch, prev_c);
            end
            prev_hold = 0;
            if (out_valid) begin
                check("hold_sel_idle", sel_n, SEL_NONE);
                if (q_c.size() == 0) check("extra_capture", out_valid, 0);
                else begin
                    check("cap_ch", out_ch, q_c[0]);
                    check("cap_data", out_data, q_d[0]);
                end
            end
            if (done) begin
                fin = 1;
                check("done_queue_empty", q_c.size(), 0);
                check("done_busy", busy, 0);
            end
            if (out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ($urandom_range(0, 99) < rdy_pct);
            end
            if (out_valid && q_c.size() <= 1) stop = 1'b1;
            if (poke && cyc == 4 && busy) begin
                start = 1'b1;
                ch_en = 4'b0001;
            end
            if (out_valid) begin
                if (out_ready) begin
                    if (ncap == 0) first_ch = out_ch;
                    ncap++;
                    if (q_c.size() > 0) begin
                        void'(q_c.pop_front());
                        void'(q_d.pop_front());
                        done_next = (q_c.size() == 0);
                    end
                end else begin
                    prev_hold = 1;
                    prev_d = out_data;
                    prev_c = out_ch;
                end
            end
            @(negedge clk);
        end
        if (!fin) check("scan_timeout", fin, 1);
        check("post_done_pulse", done, 0);
        check("post_busy", busy, 0);
        if (mask == 4'b0) check("empty_never_busy", seen_busy, 0);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] data;
        int          rdy_pct;
        int          stall;
        bit          poke;
        int          exp_caps;
        int          exp_first;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int ncap, first;
        logic [3:0] m;

        vecs[0] = '{4'b1111, 32'h44332211, 100, 0, 1'b1, 4, 0};
        vecs[1] = '{4'b1010, 32'h44332211, 100, 5, 1'b0, 2, 1};
        vecs[2] = '{4'b0000, 32'h44332211, 100, 0, 1'b0, 0, -1};
        vecs[3] = '{4'b1000, 32'hA5C3E781, 100, 0, 1'b0, 1, 3};
        vecs[4] = '{4'b0001, 32'h0F1E2D3C, 60,  3, 1'b1, 1, 0};
        vecs[5] = '{4'b0110, 32'hDEADBEEF, 100, 0, 1'b1, 2, 1};

        repeat (2) @(negedge clk);
        check("rst_sel_n", sel_n, SEL_NONE);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_scan(vecs[i].mask, vecs[i].data, vecs[i].rdy_pct, vecs[i].stall, vecs[i].poke,
                     vecs[i].exp_caps, ncap, first);
            check($sformatf("vec%0d_caps", i), ncap, vecs[i].exp_caps);
            check($sformatf("vec%0d_first", i), first, vecs[i].exp_first);
        end

        // Async reset asserted mid-SETTLE, checked before any clock edge.
        @(negedge clk);
        ch_en = 4'b1111; data_in = 32'h44332211; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pre_rst_sel", sel_n, 4'b1110);
        #2 rst = 1'b1;
        #1;
        check("async_rst_sel", sel_n, SEL_NONE);
        check("async_rst_busy", busy, 0);
        check("async_rst_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        run_scan(4'b1100, 32'h99887766, 100, 0, 1'b0, 2, ncap, first);
        check("after_rst_first", first, 2);
        check("after_rst_caps", ncap, 2);

`ifdef MUX_SCAN_CONT_EN
        run_scan(4'b0101, 32'h44332211, 100, 0, 1'b0, 3, ncap, first);
        check("cont_caps", ncap, 3);
        check("cont_first", first, 0);
`endif

        for (int i = 0; i < 16; i++) begin
            m = 4'($urandom_range(0, 15));
            run_scan(m, $urandom, $urandom_range(40, 100), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                     popcount4(m), ncap, first);
            check($sformatf("rand%0d_caps", i), ncap, popcount4(m));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
